// File: rtl/cpu_decode.sv
// Instruction decoder: turns a stream of 16-bit halfwords into decoded
// instructions. Form1 opcodes may pull a trailing 32-bit immediate (hi then lo).
module cpu_decode (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [15:0] insn_i,
    input  logic        insn_valid_i,
    output logic        insn_ready_o,
    output logic        dec_valid_o,
    input  logic        ex_ready_i,
    output logic [1:0]  form_o,
    output logic [7:0]  opcode_o,
    output logic [3:0]  reg_read_index1_o,
    output logic [3:0]  reg_read_index2_o,
    output logic        read_enable_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic [1:0] S_OP     = 2'd0;
    localparam logic [1:0] S_IMM_HI = 2'd1;
    localparam logic [1:0] S_IMM_LO = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic [1:0] FORM1 = 2'd0;
    localparam logic [1:0] FORM2 = 2'd2;
    localparam logic [1:0] FORM3 = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_form;
    logic [7:0]  r_opcode;
    logic [3:0]  r_idx1;
    logic [3:0]  r_idx2;
    logic [31:0] r_imm;
    logic        r_illegal;
    logic        r_rden;

    logic        w_accept;
    logic [1:0]  w_form;
    logic [7:0]  w_opcode;
    logic [3:0]  w_idx1;
    logic [3:0]  w_idx2;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_needs_imm;

    function automatic logic f_needs_imm(input logic [7:0] op);
        logic res;
        case (op)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
            8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
            8'h24, 8'h36, 8'h37, 8'h38, 8'h39: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    assign insn_ready_o = (r_state != S_OUT) | ex_ready_i;
    assign w_accept     = insn_valid_i & insn_ready_o;

    // Combinational decode of the current halfword as an opcode halfword.
    always_comb begin
        w_form      = FORM1;
        w_opcode    = '0;
        w_idx1      = '0;
        w_idx2      = '0;
        w_imm       = '0;
        w_illegal   = 1'b0;
        w_needs_imm = 1'b0;
        if (!insn_i[15]) begin
            w_form      = FORM1;
            w_opcode    = insn_i[15:8];
            w_idx1      = insn_i[7:4];
            w_idx2      = insn_i[3:0];
            w_illegal   = (insn_i[15:8] == 8'h00) || insn_i[14];
            w_needs_imm = f_needs_imm(insn_i[15:8]);
        end else if (!insn_i[14]) begin
            w_form   = FORM2;
            w_opcode = {6'b0, insn_i[13:12]};
            w_idx1   = insn_i[11:8];
            w_imm    = {24'b0, insn_i[7:0]};
        end else begin
            w_form   = FORM3;
            w_opcode = {4'b0, insn_i[13:10]};
            w_imm    = {{21{insn_i[9]}}, insn_i[9:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_OP;
            r_form    <= '0;
            r_opcode  <= '0;
            r_idx1    <= '0;
            r_idx2    <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_rden    <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_OP;
            r_rden  <= 1'b0;
        end else begin
            r_rden <= 1'b0;
            case (r_state)
                S_OP, S_OUT: begin
                    // In S_OUT an accept implies ex_ready_i, so the old
                    // presentation retires in the same cycle the new opcode lands.
                    if (w_accept) begin
                        r_form    <= w_form;
                        r_opcode  <= w_opcode;
                        r_idx1    <= w_idx1;
                        r_idx2    <= w_idx2;
                        r_imm     <= w_imm;
                        r_illegal <= w_illegal;
                        r_state   <= w_needs_imm ? S_IMM_HI : S_OUT;
                        r_rden    <= !w_needs_imm;
                    end else if (r_state == S_OUT && ex_ready_i) begin
                        r_state <= S_OP;
                    end
                end
                S_IMM_HI: begin
                    if (w_accept) begin
                        r_imm[31:16] <= insn_i;
                        r_state      <= S_IMM_LO;
                    end
                end
                S_IMM_LO: begin
                    if (w_accept) begin
                        r_imm[15:0] <= insn_i;
                        r_state     <= S_OUT;
                        r_rden      <= 1'b1;
                    end
                end
                default: r_state <= S_OP;
            endcase
        end
    end

    assign dec_valid_o       = (r_state == S_OUT);
    assign form_o            = r_form;
    assign opcode_o          = r_opcode;
    assign reg_read_index1_o = r_idx1;
    assign reg_read_index2_o = r_idx2;
    assign read_enable_o     = r_rden;
    assign imm_o             = r_imm;
    assign illegal_o         = r_illegal;

endmodule

// File: doc/cpu_decode.md
CPU_DECODE -- requirements
Module: cpu_decode

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port flush_i  in  1  synchronous discard of all in-flight decode state.
REQ-004 SHALL have port insn_i  in  16  instruction halfword from fetch.
REQ-005 SHALL have port insn_valid_i  in  1  insn_i valid.
REQ-006 SHALL have port insn_ready_o  out  1  decode accepts insn_i this cycle.
REQ-007 SHALL have port dec_valid_o  out  1  decoded instruction presented to execute.
REQ-008 SHALL have port ex_ready_i  in  1  execute consumes the presented instruction.
REQ-009 SHALL have port form_o  out  2  0=form1, 2=form2, 3=form3.
REQ-010 SHALL have port opcode_o  out  8  form1: insn[15:8]; form2: {6'b0,insn[13:12]}; form3: {4'b0,insn[13:10]}.
REQ-011 SHALL have port reg_read_index1_o  out  4  register A index to the register file.
REQ-012 SHALL have port reg_read_index2_o  out  4  register B index to the register file.
REQ-013 SHALL have port read_enable_o  out  1  register-file read strobe.
REQ-014 SHALL have port imm_o  out  32  immediate.
REQ-015 SHALL have port illegal_o  out  1  presented instruction is illegal.

Function
REQ-016 SHALL implement states S_OP (await opcode), S_IMM_HI, S_IMM_LO, S_OUT (present).
REQ-017 SHALL drive insn_ready_o = (state != S_OUT) | ex_ready_i, combinationally; a transfer occurs when insn_valid_i & insn_ready_o.
REQ-018 SHALL decode an accepted opcode halfword as form1 if insn[15]=0, form2 if insn[15:14]=10, form3 if insn[15:14]=11.
REQ-019 SHALL set form1 index1=insn[7:4], index2=insn[3:0]; form2 index1=insn[11:8], index2=0; form3 both 0.
REQ-020 SHALL set form2 imm_o = zero-extended insn[7:0]; form3 imm_o = sign-extended {insn[9:0],1'b0}.
REQ-021 SHALL treat form1 opcodes 0x01,0x03,0x08,0x09,0x0C,0x0D,0x1A,0x1B,0x1D,0x1F,0x20,0x22,0x24,0x36,0x37,0x38,0x39 as carrying a 32-bit immediate: next accepted halfword = imm[31:16], following = imm[15:0].
REQ-022 SHALL transition S_OP/S_OUT on opcode accept to S_IMM_HI if immediate required, else S_OUT; S_IMM_HI to S_IMM_LO on accept; S_IMM_LO to S_OUT on accept.
REQ-023 SHALL drive imm_o = 0 for form1 without immediate.
REQ-024 SHALL assert illegal_o for form1 opcode 0x00 or >= 0x40; illegal instructions are still presented normally.
REQ-025 SHALL, in S_OUT, hold dec_valid_o=1 and all decoded outputs stable until ex_ready_i=1.
REQ-026 SHALL, in S_OUT with ex_ready_i=1 and no accept, go to S_OP, dec_valid_o=0 next cycle.
REQ-027 SHALL, in S_OUT with ex_ready_i=1 and a simultaneous opcode accept, present the new instruction next cycle if it needs no immediate (back-to-back, one per cycle).
REQ-028 SHALL pulse read_enable_o for exactly one cycle, the first cycle of each new presentation, with indices valid that cycle.
REQ-029 SHALL have dec_valid_o=0 in S_OP, S_IMM_HI, S_IMM_LO.
REQ-030 SHALL, on flush_i=1, go to S_OP, drop any presented instruction or partial immediate, and deassert dec_valid_o and read_enable_o next cycle; flush_i has priority over any transfer that cycle; insn_ready_o stays as in REQ-017.

Reset
REQ-031 SHALL, while rst_i=1, force state S_OP, dec_valid_o=0, read_enable_o=0, illegal_o=0, form_o=0, opcode_o=0, both indices=0, imm_o=0, immediately and regardless of clk_i.
REQ-032 SHALL, on reset mid-immediate, discard the partial immediate; the first halfword after reset is decoded as an opcode.

Verification
REQ-033 SHALL verify: 0x0523 (form1 op 0x05) with ex_ready_i=1 -> next cycle dec_valid_o=1, index1=2, index2=3, imm_o=0, read_enable_o single pulse.
REQ-034 SHALL verify: 0x0120, 0xDEAD, 0xBEEF -> after third accept, opcode_o=0x01, index1=2, imm_o=0xDEADBEEF; dec_valid_o low during immediate fetch.
REQ-035 SHALL verify: 0xC3FF -> form_o=3, opcode_o=0x0, imm_o=0xFFFFFFFE; 0x9A7F -> form_o=2, opcode_o=1, index1=0xA, imm_o=0x7F.
REQ-036 SHALL verify: ex_ready_i=0 for 5 cycles while 0x0523 presented -> insn_ready_o=0, outputs stable, one read_enable_o pulse; then back-to-back 0x0634 accepted same cycle ex_ready_i rises.
REQ-037 SHALL verify: flush_i after 0x0120, 0xDEAD -> S_OP; next 0x0511 decodes as opcode 0x05, index1=1, index2=1.
REQ-038 SHALL verify: rst_i asserted mid-clock during S_IMM_LO -> all outputs zero immediately; 0x4000 after reset -> illegal_o=1.
